// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller.
// State encoding, gradient-mode encodings and kernel size.
package sobel_pkg;

  localparam int unsigned KERNEL = 3;

  localparam logic [1:0] MODE_H  = 2'b01;
  localparam logic [1:0] MODE_V  = 2'b10;
  localparam logic [1:0] MODE_HV = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_CALC_H,
    S_CALC_V,
    S_WRITE,
    S_SHIFT,
    S_MOVE,
    S_DONE
  } state_t;

  // 2'b00 is treated like MODE_HV: both gradients.
  function automatic logic mode_has_h(input logic [1:0] m);
    return (m != MODE_V);
  endfunction

  function automatic logic mode_has_v(input logic [1:0] m);
    return (m != MODE_H);
  endfunction

endpackage

// File: rtl/sobel_frame_controller_if.sv
// Control/handshake bundle between the frame controller and its pipeline stages.
// master = controller side, slave = stage/host side.
interface sobel_frame_controller_if #(
  parameter int unsigned COORD_W = 8
);
  logic               start;
  logic               abort;
  logic [1:0]         mode;

  logic               load_done;
  logic               read_done;
  logic               h_done;
  logic               v_done;
  logic               write_done;
  logic               shift_done;
  logic               move_done;

  logic               load_initial;
  logic               start_read;
  logic               start_h_grad;
  logic               start_v_grad;
  logic               start_write;
  logic               start_shift;
  logic               start_move;

  logic [COORD_W-1:0] win_col;
  logic [COORD_W-1:0] win_row;
  logic               busy;
  logic               frame_done;

  modport master (
    input  start, abort, mode,
    input  load_done, read_done, h_done, v_done, write_done, shift_done, move_done,
    output load_initial, start_read, start_h_grad, start_v_grad,
    output start_write, start_shift, start_move,
    output win_col, win_row, busy, frame_done
  );

  modport slave (
    output start, abort, mode,
    output load_done, read_done, h_done, v_done, write_done, shift_done, move_done,
    input  load_initial, start_read, start_h_grad, start_v_grad,
    input  start_write, start_shift, start_move,
    input  win_col, win_row, busy, frame_done
  );

endinterface

// File: rtl/sobel_pos_counter.sv
// Top-left window coordinate register with clear, column step and row advance.
// Both coordinates saturate at their maxima.
module sobel_pos_counter #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned MAX_COL = 5,
  parameter int unsigned MAX_ROW = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_clr,
  input  logic               i_inc_col,
  input  logic               i_adv_row,
  output logic [COORD_W-1:0] o_col,
  output logic [COORD_W-1:0] o_row
);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv_row) begin
      r_col <= '0;
      if (r_row != COORD_W'(MAX_ROW)) r_row <= r_row + 1'b1;
    end else if (i_inc_col && (r_col != COORD_W'(MAX_COL))) begin
      r_col <= r_col + 1'b1;
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/sobel_frame_controller.sv
// Sequences one Sobel frame: per-window load/read/gradient/write stages with
// single-cycle launch pulses, window stepping, abort and frame completion.
module sobel_frame_controller
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W   = 8,
  parameter int unsigned IMG_H   = 8,
  parameter int unsigned COORD_W = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  sobel_frame_controller_if.master  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic               r_first;
  logic               r_load_initial;
  logic               r_start_read;
  logic               r_start_h_grad;
  logic               r_start_v_grad;
  logic               r_start_write;
  logic               r_start_shift;
  logic               r_start_move;
  logic               r_frame_done;

  logic               w_enter;
  logic               w_clr;
  logic               w_inc_col;
  logic               w_adv_row;
  logic               w_col_last;
  logic               w_row_last;
  logic [COORD_W-1:0] w_col;
  logic [COORD_W-1:0] w_row;

  assign w_col_last = (w_col == COORD_W'(IMG_W - KERNEL));
  assign w_row_last = (w_row == COORD_W'(IMG_H - KERNEL));

  // r_first marks the launch-pulse cycle, in which the stage's done is ignored.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_inc_col = 1'b0;
    w_adv_row = 1'b0;
    if ((r_state != S_IDLE) && bus.abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (bus.start) begin
                    w_next = S_LOAD;
                    w_clr  = 1'b1;
                  end
        S_LOAD:   if (!r_first && bus.load_done) w_next = S_READ;
        S_READ:   if (!r_first && bus.read_done)
                    w_next = mode_has_h(r_mode) ? S_CALC_H : S_CALC_V;
        S_CALC_H: if (!r_first && bus.h_done)
                    w_next = mode_has_v(r_mode) ? S_CALC_V : S_WRITE;
        S_CALC_V: if (!r_first && bus.v_done) w_next = S_WRITE;
        S_WRITE:  if (!r_first && bus.write_done) begin
                    if (!w_col_last)      w_next = S_SHIFT;
                    else if (!w_row_last) w_next = S_MOVE;
                    else                  w_next = S_DONE;
                  end
        S_SHIFT:  if (!r_first && bus.shift_done) begin
                    w_next    = S_READ;
                    w_inc_col = 1'b1;
                  end
        S_MOVE:   if (!r_first && bus.move_done) begin
                    w_next    = S_LOAD;
                    w_adv_row = 1'b1;
                  end
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // No state loops to itself, so a state change is exactly a state entry.
  assign w_enter = (w_next != r_state) && (w_next != S_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_mode         <= MODE_HV;
      r_first        <= 1'b0;
      r_load_initial <= 1'b0;
      r_start_read   <= 1'b0;
      r_start_h_grad <= 1'b0;
      r_start_v_grad <= 1'b0;
      r_start_write  <= 1'b0;
      r_start_shift  <= 1'b0;
      r_start_move   <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state        <= w_next;
      if (w_clr) r_mode <= bus.mode;
      r_first        <= w_enter;
      r_load_initial <= w_enter && (w_next == S_LOAD);
      r_start_read   <= w_enter && (w_next == S_READ);
      r_start_h_grad <= w_enter && (w_next == S_CALC_H);
      r_start_v_grad <= w_enter && (w_next == S_CALC_V);
      r_start_write  <= w_enter && (w_next == S_WRITE);
      r_start_shift  <= w_enter && (w_next == S_SHIFT);
      r_start_move   <= w_enter && (w_next == S_MOVE);
      r_frame_done   <= w_enter && (w_next == S_DONE);
    end
  end

  sobel_pos_counter #(
    .COORD_W (COORD_W),
    .MAX_COL (IMG_W - KERNEL),
    .MAX_ROW (IMG_H - KERNEL)
  ) u_pos (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_clr     (w_clr),
    .i_inc_col (w_inc_col),
    .i_adv_row (w_adv_row),
    .o_col     (w_col),
    .o_row     (w_row)
  );

  assign bus.load_initial = r_load_initial;
  assign bus.start_read   = r_start_read;
  assign bus.start_h_grad = r_start_h_grad;
  assign bus.start_v_grad = r_start_v_grad;
  assign bus.start_write  = r_start_write;
  assign bus.start_shift  = r_start_shift;
  assign bus.start_move   = r_start_move;
  assign bus.frame_done   = r_frame_done;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.win_col      = w_col;
  assign bus.win_row      = w_row;

endmodule

// File: tb/tb_sobel_frame_controller.sv
// Randomized bench for sobel_frame_controller: a stage responder with random
// done latency/noise, and a per-frame event-sequence reference model.
module tb_sobel_frame_controller;

  localparam int unsigned IMG_W   = 5;
  localparam int unsigned IMG_H   = 4;
  localparam int unsigned COORD_W = 8;
  localparam int MAXC = IMG_W - 3;
  localparam int MAXR = IMG_H - 3;

  // Event codes: launch pulses 0..6 (load, read, h, v, write, shift, move), 7 frame_done.
  localparam int EV_LOAD = 0, EV_READ = 1, EV_H = 2, EV_V = 3, EV_WRITE = 4,
                 EV_SHIFT = 5, EV_MOVE = 6, EV_DONE = 7;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sobel_frame_controller_if #(.COORD_W(COORD_W)) bus();

  sobel_frame_controller #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .COORD_W (COORD_W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int obs_ev[$];
  int obs_pos[$];
  int cyc = 0;

  bit resp_en    = 1'b1;
  bit noise_en   = 1'b0;
  bit hold_write = 1'b0;
  bit abort_arm  = 1'b0;
  bit abort_fired = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pulse_vec();
    return {bus.frame_done, bus.start_move, bus.start_shift, bus.start_write,
            bus.start_v_grad, bus.start_h_grad, bus.start_read, bus.load_initial};
  endfunction

  function automatic int cur_pos();
    return int'({bus.win_col, bus.win_row});
  endfunction

  task automatic drive_done(input logic [6:0] dv);
    bus.load_done  = dv[0];
    bus.read_done  = dv[1];
    bus.h_done     = dv[2];
    bus.v_done     = dv[3];
    bus.write_done = dv[4] | hold_write;
    bus.shift_done = dv[5];
    bus.move_done  = dv[6];
  endtask

  // Monitor + responder: all done/abort driving happens on the falling edge.
  initial begin
    int pend, cur, target, adv_cyc, lat;
    logic [7:0] pv;
    logic [6:0] dv;
    pend = -1; cur = -1; target = 0; adv_cyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.abort = 1'b0;
      if (!n_rst) begin
        pend = -1; cur = -1; adv_cyc = -1;
        drive_done('0);
        continue;
      end
      pv = pulse_vec();
      for (int i = 0; i < 8; i++)
        if (pv[i]) begin
          obs_ev.push_back(i);
          obs_pos.push_back(cur_pos());
        end
      if (adv_cyc == cyc) begin
        check_val("advance_after_done", 32'(|pv), 32'd1);
        adv_cyc = -1;
      end
      dv = '0;
      if (resp_en && (pv[6:0] != '0)) begin
        for (int i = 0; i < 7; i++) if (pv[i]) pend = i;
        cur = pend;
        lat = (hold_write && pend == EV_WRITE) ? 1 : int'($urandom_range(1, 3));
        target = cyc + lat;
        // Done raised in the pulse cycle must be ignored by the DUT.
        if (!(hold_write && pend == EV_WRITE) && ($urandom_range(0, 1) == 1)) dv[pend] = 1'b1;
      end else if (pend >= 0 && cyc == target) begin
        if (!(hold_write && pend == EV_WRITE)) dv[pend] = 1'b1;
        if (abort_arm && pend == EV_V && bus.win_col == 1 && bus.win_row == 0) begin
          bus.abort   = 1'b1;
          abort_arm   = 1'b0;
          abort_fired = 1'b1;
        end else begin
          adv_cyc = cyc + 1;
        end
        pend = -1;
      end
      if (noise_en)
        for (int i = 0; i < 7; i++)
          if (i != cur && $urandom_range(0, 7) == 0) dv[i] = 1'b1;
      drive_done(dv);
    end
  end

  function automatic bit has_h(input logic [1:0] m);
    case (m)
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit has_v(input logic [1:0] m);
    case (m)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_frame(input logic [1:0] m, input bit busy_noise);
    bit got_done;
    got_done = 1'b0;
    obs_ev.delete();
    obs_pos.delete();
    @(negedge clk); #1;
    bus.mode  = m;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = 2'($urandom);
    for (int k = 0; k < 3000 && !got_done; k++) begin
      @(negedge clk); #1;
      if (obs_ev.size() > 0 && obs_ev[obs_ev.size()-1] == EV_DONE) got_done = 1'b1;
      if (busy_noise) bus.start = bus.busy && ($urandom_range(0, 3) == 0);
      bus.mode = 2'($urandom);
    end
    bus.start = 1'b0;
    check_val("frame_done_seen", 32'(got_done), 32'd1);
  endtask

  // Reference: window raster order and stage list per window, from the mode table.
  task automatic check_frame(input logic [1:0] m, input string tag);
    int exp_ev[$];
    int exp_pos[$];
    int n, cnt_w, cnt_h, cnt_v, cnt_l, cnt_s, cnt_m, cnt_d;
    for (int r = 0; r <= MAXR; r++) begin
      exp_ev.push_back(EV_LOAD); exp_pos.push_back(r);
      for (int c = 0; c <= MAXC; c++) begin
        exp_ev.push_back(EV_READ); exp_pos.push_back(c * 256 + r);
        if (has_h(m)) begin exp_ev.push_back(EV_H); exp_pos.push_back(c * 256 + r); end
        if (has_v(m)) begin exp_ev.push_back(EV_V); exp_pos.push_back(c * 256 + r); end
        exp_ev.push_back(EV_WRITE); exp_pos.push_back(c * 256 + r);
        if (c < MAXC)      exp_ev.push_back(EV_SHIFT);
        else if (r < MAXR) exp_ev.push_back(EV_MOVE);
        else               exp_ev.push_back(EV_DONE);
        exp_pos.push_back(c * 256 + r);
      end
    end
    check_val({tag, "/len"}, 32'(obs_ev.size()), 32'(exp_ev.size()));
    n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s/ev%0d", tag, i), 32'(obs_ev[i]), 32'(exp_ev[i]));
      check_val($sformatf("%s/pos%0d", tag, i), 32'(obs_pos[i]), 32'(exp_pos[i]));
    end
    cnt_w = 0; cnt_h = 0; cnt_v = 0; cnt_l = 0; cnt_s = 0; cnt_m = 0; cnt_d = 0;
    foreach (obs_ev[i]) begin
      case (obs_ev[i])
        EV_WRITE: cnt_w++;
        EV_H:     cnt_h++;
        EV_V:     cnt_v++;
        EV_LOAD:  cnt_l++;
        EV_SHIFT: cnt_s++;
        EV_MOVE:  cnt_m++;
        EV_DONE:  cnt_d++;
        default: ;
      endcase
    end
    check_val({tag, "/n_write"}, 32'(cnt_w), 32'((IMG_W-2)*(IMG_H-2)));
    check_val({tag, "/n_h"},     32'(cnt_h), has_h(m) ? 32'((IMG_W-2)*(IMG_H-2)) : 32'd0);
    check_val({tag, "/n_v"},     32'(cnt_v), has_v(m) ? 32'((IMG_W-2)*(IMG_H-2)) : 32'd0);
    check_val({tag, "/n_load"},  32'(cnt_l), 32'(IMG_H-2));
    check_val({tag, "/n_shift"}, 32'(cnt_s), 32'((IMG_W-3)*(IMG_H-2)));
    check_val({tag, "/n_move"},  32'(cnt_m), 32'(IMG_H-3));
    check_val({tag, "/n_done"},  32'(cnt_d), 32'd1);
    @(negedge clk); #1;
    check_val({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "/final_col"}, 32'(bus.win_col), 32'(MAXC));
    check_val({tag, "/final_row"}, 32'(bus.win_row), 32'(MAXR));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m;
    int n_ev, n_wr;
    bit seen;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    drive_done('0);
    bus.abort = 1'b0;

    #3;
    check_val("rst/busy",  32'(bus.busy), 32'd0);
    check_val("rst/pulses", 32'(pulse_vec()), 32'd0);
    check_val("rst/col",   32'(bus.win_col), 32'd0);
    check_val("rst/row",   32'(bus.win_row), 32'd0);
    #20 n_rst = 1'b1;

    run_frame(2'b11, 1'b0); check_frame(2'b11, "hv");
    run_frame(2'b01, 1'b0); check_frame(2'b01, "h_only");
    run_frame(2'b10, 1'b0); check_frame(2'b10, "v_only");
    run_frame(2'b00, 1'b0); check_frame(2'b00, "mode00");

    noise_en = 1'b1;
    hold_write = 1'b1;
    run_frame(2'b11, 1'b0); check_frame(2'b11, "hold_write");
    hold_write = 1'b0;

    for (int f = 0; f < 4; f++) begin
      m = 2'($urandom);
      run_frame(m, 1'b1);
      check_frame(m, $sformatf("rand%0d", f));
    end

    // Abort in CALC_V of window (1,0), together with v_done.
    noise_en = 1'b0;
    abort_arm = 1'b1;
    abort_fired = 1'b0;
    obs_ev.delete(); obs_pos.delete();
    @(negedge clk); #1;
    bus.mode = 2'b11; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 2000 && !abort_fired; k++) begin
      @(negedge clk); #1;
    end
    check_val("abort/fired", 32'(abort_fired), 32'd1);
    @(negedge clk); #1;
    check_val("abort/busy",   32'(bus.busy), 32'd0);
    check_val("abort/pulses", 32'(pulse_vec()), 32'd0);
    check_val("abort/col",    32'(bus.win_col), 32'd1);
    check_val("abort/row",    32'(bus.win_row), 32'd0);
    n_ev = obs_ev.size();
    repeat (5) @(negedge clk);
    #1;
    check_val("abort/no_events", 32'(obs_ev.size()), 32'(n_ev));
    n_wr = 0;
    foreach (obs_ev[i]) if (obs_ev[i] == EV_WRITE) n_wr++;
    check_val("abort/n_write", 32'(n_wr), 32'd1);
    check_val("abort/col_hold", 32'(bus.win_col), 32'd1);
    abort_arm = 1'b0;

    // Asynchronous reset mid-SHIFT.
    obs_ev.delete(); obs_pos.delete();
    @(negedge clk); #1;
    bus.mode = 2'b11; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk); #1;
      seen = bus.start_shift;
    end
    check_val("rst_mid/shift_seen", 32'(seen), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check_val("rst_mid/busy",   32'(bus.busy), 32'd0);
    check_val("rst_mid/pulses", 32'(pulse_vec()), 32'd0);
    check_val("rst_mid/col",    32'(bus.win_col), 32'd0);
    check_val("rst_mid/row",    32'(bus.win_row), 32'd0);
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;
    noise_en = 1'b1;
    run_frame(2'b11, 1'b1); check_frame(2'b11, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_controller.md
SOBEL_FRAME_CONTROLLER -- requirements
Module: sobel_frame_controller

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels, SHALL be >= 3.
REQ-002 Parameter IMG_H, default 8: image height in pixels, SHALL be >= 3.
REQ-003 Parameter COORD_W, default 8: coordinate width, SHALL satisfy 2**COORD_W >= max(IMG_W, IMG_H).
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin one frame; sampled in IDLE only.
REQ-007 abort  in  1  synchronous abandon of the current frame.
REQ-008 mode  in  2  gradient select, latched at start: 01 H only, 10 V only, 11 or 00 both.
REQ-009 load_done, read_done, h_done, v_done, write_done, shift_done, move_done  in  1 each  stage completion strobes.
REQ-010 load_initial, start_read, start_h_grad, start_v_grad, start_write, start_shift, start_move  out  1 each  single-cycle stage launch pulses.
REQ-011 win_col, win_row  out  COORD_W each  top-left coordinate of the current 3x3 window.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 frame_done  out  1  single-cycle pulse when the frame completes.

Function
REQ-014 States SHALL be IDLE, LOAD, READ, CALC_H, CALC_V, WRITE, SHIFT, MOVE, DONE.
REQ-015 IDLE->LOAD on start=1, latching mode and clearing win_col and win_row to 0.
REQ-016 Each stage state SHALL assert its launch pulse registered for exactly the first cycle of that state (LOAD->load_initial, READ->start_read, CALC_H->start_h_grad, CALC_V->start_v_grad, WRITE->start_write, SHIFT->start_shift, MOVE->start_move).
REQ-017 The state's done strobe SHALL be ignored in the pulse cycle and accepted on any later cycle; the state SHALL wait indefinitely until it is accepted.
REQ-018 Done strobes not belonging to the current state SHALL be ignored.
REQ-019 LOAD->READ on load_done.
REQ-020 READ->CALC_H on read_done when mode has H; otherwise READ->CALC_V.
REQ-021 CALC_H->CALC_V on h_done when mode is both; otherwise CALC_H->WRITE.
REQ-022 CALC_V->WRITE on v_done.
REQ-023 WRITE exit on write_done:
  - win_col < IMG_W-3: go to SHIFT.
  - win_col = IMG_W-3 and win_row < IMG_H-3: go to MOVE.
  - Both at their maxima: go to DONE.
REQ-024 SHIFT->READ on shift_done, with win_col incremented by 1.
REQ-025 MOVE->LOAD on move_done, with win_col cleared to 0 and win_row incremented by 1.
REQ-026 DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE; the coordinates hold their final values.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge. No launch pulse or frame_done SHALL be issued, and the coordinates hold.
REQ-028 abort has priority over any done strobe in the same cycle.
REQ-029 start while busy SHALL be ignored.
REQ-030 Coordinates SHALL never exceed IMG_W-3 / IMG_H-3; no wrap-around.
REQ-031 A frame SHALL issue exactly (IMG_W-2)*(IMG_H-2) start_write pulses, IMG_H-2 load_initial pulses and IMG_H-3 start_move pulses.

Reset
REQ-032 On n_rst=0, the FSM SHALL be in IDLE, all pulse outputs, busy and frame_done 0, win_col=0, win_row=0, latched mode=11.
REQ-033 Reset mid-frame SHALL take effect immediately without waiting for the clock.
REQ-034 After reset release, the first start SHALL begin a fresh frame.

Structure
REQ-035 Package sobel_pkg SHALL hold the state enum, the mode encodings (MODE_H=01, MODE_V=10, MODE_HV=11) and KERNEL=3.
REQ-036 One sub-module sobel_pos_counter SHALL hold win_col/win_row with clear, col-increment and row-advance controls.

Verification
REQ-037 IMG_W=5, IMG_H=4, mode=11, every done 2 cycles after its pulse -> 6 start_write, 6 start_h_grad, 6 start_v_grad, 4 start_shift, 1 start_move, 2 load_initial, then one frame_done; final win_col=2, win_row=1.
REQ-038 mode=01 on same frame -> 0 start_v_grad, 6 start_h_grad; mode=10 -> 0 start_h_grad, 6 start_v_grad.
REQ-039 write_done held high continuously from reset -> no WRITE exit in the pulse cycle; exactly one start_write per window.
REQ-040 abort asserted in CALC_V of window (1,0), together with v_done -> IDLE next cycle, busy=0, no start_write, win_col=1, win_row=0 held.
REQ-041 n_rst asserted low mid-SHIFT -> busy, all pulses and coordinates 0 immediately; a following start restarts at (0,0) with load_initial.
REQ-042 start pulsed while busy -> no effect on state or coordinates.
